xregfile_mbist_ctrl: RTL and testbench

//  March C- MBIST engine for the register-file test wrapper BIST port (BIST/CSN_T/WEN_T/A_T/D_T/Q_T).

---
 rtl/xregfile_mbist_ctrl.sv | 149 ++++++++++++++
 tb/tb_xregfile_mbist_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/xregfile_mbist_ctrl.sv
// xregfile_mbist_ctrl: March C- MBIST engine for the register-file wrapper BIST port
//   Build option: define BIST_DIAG_EN to capture the first failure and count mismatches;
//   without it the diagnostic ports are tied to 0.
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         launch pulse, accepted in IDLE/DONE
//   bist_o          wrapper BIST select, high in RUN/DRAIN
//   csn_t_o/wen_t_o chip select (active low) / 0=write 1=read
//   a_t_o/d_t_o     logical address (MSB 0) / write data
//   q_t_i           wrapper read data, valid the cycle after a read
//   busy_o/done_o/pass_o   status; pass_o valid with done_o
//   fail_addr_o/fail_exp_o/fail_act_o/err_cnt_o   first-failure diagnostics, mismatch count
module xregfile_mbist_ctrl #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] DATA_BG    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  bist_o,
  output logic                  csn_t_o,
  output logic                  wen_t_o,
  output logic [ADDR_WIDTH-1:0] a_t_o,
  output logic [DATA_WIDTH-1:0] d_t_o,
  input  logic [DATA_WIDTH-1:0] q_t_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_exp_o,
  output logic [DATA_WIDTH-1:0] fail_act_o,
  output logic [7:0]            err_cnt_o
);
  localparam int LW = ADDR_WIDTH - 1;
  // Highest issued logical address; all-ones maps to unwritable phys 0.
  localparam logic [LW-1:0] LAST = LW'(2**LW - 2);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t          state_q, state_d;
  logic [2:0]      elem_q, elem_d;
  logic [LW-1:0]   addr_q, addr_d;
  logic            ph_q, ph_d;
  logic            pend_vld_q, pass_q;
  logic [DATA_WIDTH-1:0] pend_exp_q;
  logic            run, launch, dn, single, is_rd, op_last, addr_end, mismatch;
  logic [DATA_WIDTH-1:0] exp_d;
  // Elements M0 and M5 issue one op per address; M1-M4 issue read then write (ph_q).
  assign run      = state_q == RUN;
  assign launch   = start_i && (state_q == IDLE || state_q == DONE);
  assign dn       = elem_q >= 3'd3;
  assign single   = elem_q == 3'd0 || elem_q == 3'd5;
  assign is_rd    = elem_q == 3'd5 || (!single && !ph_q);
  assign op_last  = single || ph_q;
  assign addr_end = dn ? addr_q == '0 : addr_q == LAST;
  assign exp_d    = (elem_q == 3'd2 || elem_q == 3'd4) ? ~DATA_BG : DATA_BG;
  assign mismatch = pend_vld_q && q_t_i != pend_exp_q;
  assign bist_o   = run || state_q == DRAIN;
  assign busy_o   = bist_o;
  assign done_o   = state_q == DONE;
  assign pass_o   = done_o && pass_q;
  assign csn_t_o  = !run;
  assign wen_t_o  = !run || is_rd;
  assign a_t_o    = run ? {1'b0, addr_q} : '0;
  assign d_t_o    = (run && !is_rd) ? ((elem_q == 3'd1 || elem_q == 3'd3) ? ~DATA_BG : DATA_BG) : '0;
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    ph_d    = ph_q;
    case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = RUN;
        elem_d  = '0;
        addr_d  = '0;
        ph_d    = 1'b0;
      end
      RUN: begin
        ph_d = !op_last;
        if (op_last && !addr_end) addr_d = dn ? addr_q - LW'(1) : addr_q + LW'(1);
        if (op_last && addr_end) begin
          if (elem_q == 3'd5) state_d = DRAIN;
          else begin
            elem_d = elem_q + 3'd1;
            addr_d = elem_q >= 3'd2 ? LAST : '0;
          end
        end
      end
      default: state_d = DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      elem_q     <= '0;
      addr_q     <= '0;
      ph_q       <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_exp_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      addr_q     <= addr_d;
      ph_q       <= ph_d;
      pend_vld_q <= run && is_rd;
      pend_exp_q <= exp_d;
      if (launch) pass_q <= 1'b1;
      else if (mismatch) pass_q <= 1'b0;
    end
  end
`ifdef BIST_DIAG_EN
  logic [LW-1:0]         pend_addr_q, fail_addr_q;
  logic [DATA_WIDTH-1:0] fail_exp_q, fail_act_q;
  logic [7:0]            err_cnt_q;
  // pass_q still set means this mismatch is the first of the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_addr_q <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      pend_addr_q <= addr_q;
      if (launch) begin
        fail_addr_q <= '0;
        fail_exp_q  <= '0;
        fail_act_q  <= '0;
        err_cnt_q   <= '0;
      end else if (mismatch) begin
        if (pass_q) begin
          fail_addr_q <= pend_addr_q;
          fail_exp_q  <= pend_exp_q;
          fail_act_q  <= q_t_i;
        end
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end
  assign fail_addr_o = {1'b0, fail_addr_q};
  assign fail_exp_o  = fail_exp_q;
  assign fail_act_o  = fail_act_q;
  assign err_cnt_o   = err_cnt_q;
`else
  assign fail_addr_o = '0;
  assign fail_exp_o  = '0;
  assign fail_act_o  = '0;
  assign err_cnt_o   = '0;
`endif
endmodule

// File: tb/tb_xregfile_mbist_ctrl.sv
// tb_xregfile_mbist_ctrl: directed and randomized fault runs against a March C- reference model
module tb_xregfile_mbist_ctrl;
  localparam int N    = 15;
  localparam int NOPS = 10 * N;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        bist_o, csn_t_o, wen_t_o, busy_o, done_o, pass_o;
  logic [4:0]  a_t_o, fail_addr_o;
  logic [31:0] d_t_o, q_t_i, fail_exp_o, fail_act_o;
  logic [7:0]  err_cnt_o;
  int passed = 0, total = 0;
  bit sa_en = 0, sa_val = 0, cf_en = 0;
  int sa_phys = 0, sa_bit = 0, cf_agg = 0, cf_vic = 0;
  logic [31:0] mem [16];
  bit          ewe [NOPS];
  logic [4:0]  ea  [NOPS];
  logic [31:0] ed  [NOPS];
  int          nops;
  bit          r_pass;
  logic [4:0]  r_faddr;
  logic [31:0] r_fexp, r_fact;
  int          r_errs;
  xregfile_mbist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .bist_o(bist_o), .csn_t_o(csn_t_o),
    .wen_t_o(wen_t_o), .a_t_o(a_t_o), .d_t_o(d_t_o), .q_t_i(q_t_i), .busy_o(busy_o),
    .done_o(done_o), .pass_o(pass_o), .fail_addr_o(fail_addr_o), .fail_exp_o(fail_exp_o),
    .fail_act_o(fail_act_o), .err_cnt_o(err_cnt_o)
  );
  always #5 clk = ~clk;
  function automatic int phys(input logic [4:0] a);
    return int'(~a[3:0]);
  endfunction
  function automatic logic [31:0] rd_fault(input int p, input logic [31:0] v);
    logic [31:0] r;
    r = v;
    if (sa_en && p == sa_phys) r[sa_bit] = sa_val;
    return r;
  endfunction
  // Wrapper model: phys = ~A_T[3:0], phys 0 read-only, registered read data.
  always @(posedge clk) begin
    if (bist_o && !csn_t_o) begin
      if (!wen_t_o) begin
        if (phys(a_t_o) != 0) mem[phys(a_t_o)] <= d_t_o;
        if (cf_en && a_t_o == 5'(cf_agg)) mem[phys(5'(cf_vic))] <= ~mem[phys(5'(cf_vic))];
      end else q_t_i <= rd_fault(phys(a_t_o), mem[phys(a_t_o)]);
    end
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic push(input bit we, input int a, input logic [31:0] d);
    ewe[nops] = we;
    ea[nops]  = 5'(a);
    ed[nops]  = d;
    nops++;
  endtask
  // March C- as a table of elements, then replayed on an array with the injected fault.
  task automatic build_ref();
    logic [31:0] m [16];
    logic [31:0] bg, act;
    int a;
    bg = 32'h0;
    nops = 0;
    for (int e = 0; e < 6; e++)
      for (int k = 0; k < N; k++) begin
        a = e >= 3 ? N - 1 - k : k;
        case (e)
          0: push(1, a, bg);
          1: begin push(0, a, bg);  push(1, a, ~bg); end
          2: begin push(0, a, ~bg); push(1, a, bg);  end
          3: begin push(0, a, bg);  push(1, a, ~bg); end
          4: begin push(0, a, ~bg); push(1, a, bg);  end
          default: push(0, a, bg);
        endcase
      end
    for (int i = 0; i < 16; i++) m[i] = 32'h0;
    r_pass = 1; r_faddr = 0; r_fexp = 0; r_fact = 0; r_errs = 0;
    for (int i = 0; i < nops; i++) begin
      if (ewe[i]) begin
        if (phys(ea[i]) != 0) m[phys(ea[i])] = ed[i];
        if (cf_en && ea[i] == 5'(cf_agg)) m[phys(5'(cf_vic))] = ~m[phys(5'(cf_vic))];
      end else begin
        act = rd_fault(phys(ea[i]), m[phys(ea[i])]);
        if (act != ed[i]) begin
          if (r_pass) begin r_faddr = ea[i]; r_fexp = ed[i]; r_fact = act; end
          r_pass = 0;
          r_errs++;
        end
      end
    end
  endtask
  task automatic run_march(input int mid);
    build_ref();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    check("launch_done_clear", {done_o, pass_o}, 2'b00);
    for (int i = 0; i < NOPS; i++) begin
      check($sformatf("op%0d", i), {bist_o, busy_o, csn_t_o, wen_t_o, a_t_o, d_t_o},
            {1'b1, 1'b1, 1'b0, !ewe[i], ea[i], ewe[i] ? ed[i] : 32'h0});
      if (i == mid) start = 1;
      @(posedge clk); #1 start = 0;
    end
    check("drain", {bist_o, busy_o, csn_t_o, wen_t_o, done_o}, 5'b11110);
    @(posedge clk); #1;
    check("done", {bist_o, busy_o, csn_t_o, wen_t_o, done_o}, 5'b00111);
    check("pass", pass_o, r_pass);
`ifdef BIST_DIAG_EN
    check("fail_addr", fail_addr_o, r_faddr);
    check("fail_exp", fail_exp_o, r_fexp);
    check("fail_act", fail_act_o, r_fact);
    check("err_cnt", err_cnt_o, r_errs > 255 ? 255 : r_errs);
`else
    check("diag_tied", {fail_addr_o, fail_exp_o, err_cnt_o}, 45'h0);
    check("diag_act_tied", fail_act_o, 32'h0);
`endif
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", {bist_o, busy_o, csn_t_o, wen_t_o, done_o, pass_o}, 6'b001100);
    check("rst_bus", {a_t_o, d_t_o}, 37'h0);
    check("rst_diag", {fail_addr_o, fail_exp_o, err_cnt_o}, 45'h0);
    rst_n = 1;
    run_march(-1);
    run_march($urandom_range(5, NOPS - 5));
    sa_en = 1; sa_phys = 5; sa_bit = 3; sa_val = 1;
    run_march(-1);
    sa_en = 0;
    cf_en = 1; cf_agg = 4; cf_vic = 3;
    run_march(-1);
    cf_en = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    repeat (70) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("rst_mid", {bist_o, busy_o, csn_t_o, wen_t_o, done_o, pass_o}, 6'b001100);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run_march(-1);
    for (int r = 0; r < 3; r++) begin
      sa_en = 1;
      sa_phys = $urandom_range(1, 15);
      sa_bit = $urandom_range(0, 31);
      sa_val = 1'($urandom_range(0, 1));
      run_march($urandom_range(0, NOPS - 1));
    end
    sa_en = 0;
    run_march(-1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
